// File: rtl/conv_pool_engine_if.sv
// Handshake, image-ROM and layer-memory bus of the conv/pool engine.
// master = engine side, slave = image ROM / layer memory / host side.
interface conv_pool_engine_if #(
  parameter int AW = 12,
  parameter int DW = 20
);
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          k_we;
  logic [3:0]    k_idx;
  logic [DW-1:0] k_data;
  logic [1:0]    pool_mode;

  modport master (
    input  ready, idata, cdata_rd, k_we, k_idx, k_data, pool_mode,
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, cdata_rd, k_we, k_idx, k_data, pool_mode,
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/conv_pool_engine.sv
// 3x3 zero-padded convolution + bias + ReLU into bank 1, then an optional
// 2x2 stride-2 max/avg pool from bank 1 into bank 3.
//
// state  | meaning
// IDLE   | waiting for ready; kernel/bias registers writable
// CONV   | 11 cycles per pixel: 9 tap fetches, last capture, bank-1 write
// POOL   | 6 cycles per window: 4 bank-1 reads, last capture, bank-3 write
// DONE   | one cycle, busy drops on the edge leaving it
module conv_pool_engine #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 20,
  parameter int FRAC  = 16,
  parameter int AW    = 12
) (
  input logic                clk,
  input logic                reset,
  conv_pool_engine_if.master bus
);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int PCW   = $clog2(IMG_W / 2);
  localparam int PRW   = $clog2(IMG_H / 2);
  localparam int ACC_W = 2 * DW + 4;
  localparam logic [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_POOL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [RW-1:0]            r_q, r_d;
  logic [CW-1:0]            c_q, c_d;
  logic [3:0]               slot_q, slot_d;
  logic                     tap_in_q, tap_in_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]            iaddr_q, iaddr_d;
  logic [PRW-1:0]           pr_q, pr_d;
  logic [PCW-1:0]           pc_q, pc_d;
  logic [2:0]               pcnt_q, pcnt_d;
  logic [DW-1:0]            pv_q [4];
  logic [DW-1:0]            pv_d [4];
  logic [DW-1:0]            kern_q [10];
  logic [DW-1:0]            kern_d [10];

  logic                     cwr_o, crd_o;
  logic [2:0]               csel_o;
  logic [AW-1:0]            caddr_wr_o, caddr_rd_o;
  logic [DW-1:0]            cdata_wr_o;

  logic [1:0]               tr, tc;
  logic                     row_ok, col_ok, tap_ok;
  logic [AW-1:0]            tap_addr, pix_addr, pool_rd_addr, pool_wr_addr;
  logic [3:0]               tap_sel;
  logic signed [2*DW-1:0]   px, kx, prod;
  logic signed [ACC_W-1:0]  prod_ext, acc_rnd;
  logic [DW-1:0]            conv_sum, conv_res;
  logic [DW-1:0]            m01, m23, pool_max, pool_avg, pool_res;
  logic signed [DW+1:0]     psum, pshift;
  logic                     last_pix, last_win;

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.iaddr    = iaddr_d;
  assign bus.cwr      = cwr_o;
  assign bus.crd      = crd_o;
  assign bus.csel     = csel_o;
  assign bus.caddr_wr = caddr_wr_o;
  assign bus.caddr_rd = caddr_rd_o;
  assign bus.cdata_wr = cdata_wr_o;

  // Tap geometry, MAC product and conv result for the current pixel/slot.
  always_comb begin
    tr       = 2'(slot_q / 4'd3);
    tc       = 2'(slot_q % 4'd3);
    row_ok   = (tr == 2'd0) ? (r_q != '0) :
               (tr == 2'd2) ? (r_q != RW'(IMG_H - 1)) : 1'b1;
    col_ok   = (tc == 2'd0) ? (c_q != '0) :
               (tc == 2'd2) ? (c_q != CW'(IMG_W - 1)) : 1'b1;
    tap_ok   = row_ok && col_ok;
    tap_addr = AW'((int'(r_q) + int'(tr) - 1) * IMG_W + int'(c_q) + int'(tc) - 1);
    pix_addr = AW'(int'(r_q) * IMG_W + int'(c_q));
    last_pix = (r_q == RW'(IMG_H - 1)) && (c_q == CW'(IMG_W - 1));
    // slot s (1..9) captures the data fetched for tap s-1
    tap_sel  = (slot_q != 4'd0 && slot_q <= 4'd9) ? slot_q - 4'd1 : 4'd0;
    px       = {{DW{bus.idata[DW-1]}}, bus.idata};
    kx       = {{DW{kern_q[tap_sel][DW-1]}}, kern_q[tap_sel]};
    prod     = px * kx;
    prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
    acc_rnd  = acc_q + $signed(RND_HALF);
    conv_sum = acc_rnd[FRAC+DW-1:FRAC] + kern_q[9];
    conv_res = (conv_sum[DW-1] || conv_sum == '0) ? '0 : conv_sum;
  end

  // Pool window addressing and max / truncated-average reduction.
  always_comb begin
    pool_rd_addr = AW'((2 * int'(pr_q) + int'(pcnt_q[1])) * IMG_W
                       + 2 * int'(pc_q) + int'(pcnt_q[0]));
    pool_wr_addr = AW'(int'(pr_q) * (IMG_W / 2) + int'(pc_q));
    last_win     = (pr_q == PRW'(IMG_H / 2 - 1)) && (pc_q == PCW'(IMG_W / 2 - 1));
    m01          = ($signed(pv_q[0]) > $signed(pv_q[1])) ? pv_q[0] : pv_q[1];
    m23          = ($signed(pv_q[2]) > $signed(pv_q[3])) ? pv_q[2] : pv_q[3];
    pool_max     = ($signed(m01) > $signed(m23)) ? m01 : m23;
    psum         = {{2{pv_q[0][DW-1]}}, pv_q[0]} + {{2{pv_q[1][DW-1]}}, pv_q[1]}
                 + {{2{pv_q[2][DW-1]}}, pv_q[2]} + {{2{pv_q[3][DW-1]}}, pv_q[3]};
    pshift       = psum >>> 2;
    pool_avg     = pshift[DW-1:0];
    pool_res     = (mode_q == 2'd1) ? pool_max : pool_avg;
  end

  // Kernel/bias register file, writable only while idle.
  always_comb begin
    kern_d = kern_q;
    if (bus.k_we && state_q == S_IDLE && bus.k_idx <= 4'd9)
      kern_d[bus.k_idx] = bus.k_data;
  end

  // Sequencer next-state and bus outputs.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    r_d        = r_q;
    c_d        = c_q;
    slot_d     = slot_q;
    tap_in_d   = tap_in_q;
    acc_d      = acc_q;
    iaddr_d    = iaddr_q;
    pr_d       = pr_q;
    pc_d       = pc_q;
    pcnt_d     = pcnt_q;
    pv_d       = pv_q;
    cwr_o      = 1'b0;
    crd_o      = 1'b0;
    csel_o     = 3'd0;
    caddr_wr_o = '0;
    caddr_rd_o = '0;
    cdata_wr_o = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.ready) begin
          state_d = S_CONV;
          mode_d  = bus.pool_mode;
          r_d     = '0;
          c_d     = '0;
          slot_d  = '0;
        end
      end
      S_CONV: begin
        csel_o = 3'd1;
        if (slot_q <= 4'd8) begin
          tap_in_d = tap_ok;
          // padded taps leave iaddr where it was
          if (tap_ok) iaddr_d = tap_addr;
        end
        if (slot_q == 4'd0) acc_d = '0;
        else if (slot_q <= 4'd9 && tap_in_q) acc_d = acc_q + prod_ext;
        if (slot_q == 4'd10) begin
          cwr_o      = 1'b1;
          caddr_wr_o = pix_addr;
          cdata_wr_o = conv_res;
          slot_d     = '0;
          if (c_q == CW'(IMG_W - 1)) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
          if (last_pix) begin
            pr_d    = '0;
            pc_d    = '0;
            pcnt_d  = '0;
            state_d = (mode_q == 2'd1 || mode_q == 2'd2) ? S_POOL : S_DONE;
          end
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      S_POOL: begin
        csel_o = 3'd1;
        if (pcnt_q <= 3'd3) begin
          crd_o      = 1'b1;
          caddr_rd_o = pool_rd_addr;
        end
        if (pcnt_q != 3'd0 && pcnt_q <= 3'd4)
          pv_d[2'(pcnt_q - 3'd1)] = bus.cdata_rd;
        if (pcnt_q == 3'd5) begin
          cwr_o      = 1'b1;
          csel_o     = 3'd3;
          caddr_wr_o = pool_wr_addr;
          cdata_wr_o = pool_res;
          pcnt_d     = '0;
          if (pc_q == PCW'(IMG_W / 2 - 1)) begin
            pc_d = '0;
            pr_d = pr_q + 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
          if (last_win) state_d = S_DONE;
        end else begin
          pcnt_d = pcnt_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      slot_q   <= '0;
      tap_in_q <= 1'b0;
      acc_q    <= '0;
      iaddr_q  <= '0;
      pr_q     <= '0;
      pc_q     <= '0;
      pcnt_q   <= '0;
      for (int i = 0; i < 4; i++) pv_q[i] <= '0;
      for (int i = 0; i < 10; i++) kern_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      r_q      <= r_d;
      c_q      <= c_d;
      slot_q   <= slot_d;
      tap_in_q <= tap_in_d;
      acc_q    <= acc_d;
      iaddr_q  <= iaddr_d;
      pr_q     <= pr_d;
      pc_q     <= pc_d;
      pcnt_q   <= pcnt_d;
      pv_q     <= pv_d;
      kern_q   <= kern_d;
    end
  end
endmodule

// File: tb/tb_conv_pool_engine.sv
// Directed bench for conv_pool_engine on a 4x4 image.
module tb_conv_pool_engine;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int DW    = 20;
  localparam int FRAC  = 16;
  localparam int AW    = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_pool_engine_if #(.AW(AW), .DW(DW)) bus ();

  conv_pool_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .FRAC(FRAC), .AW(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] rom     [NPIX];
  logic [DW-1:0] bank1   [NPIX];
  logic [DW-1:0] exp_map [NPIX];
  logic [AW-1:0] conv_addr [$];
  logic [DW-1:0] conv_data [$];
  logic [AW-1:0] pool_addr [$];
  logic [DW-1:0] pool_data [$];
  int overlap_cnt  = 0;
  int bad_csel_cnt = 0;

  // neighbour counts of each pixel in a 4x4 image (3x3 window, zero padding)
  int nbr [NPIX] = '{4, 6, 6, 4, 6, 9, 9, 6, 6, 9, 9, 6, 4, 6, 6, 4};

  // image ROM and bank-1 read port: data valid the cycle after the address
  always @(posedge clk) begin
    bus.idata <= rom[bus.iaddr];
    if (bus.crd) bus.cdata_rd <= bank1[bus.caddr_rd];
  end

  // layer-memory write side: log every write per bank
  always @(negedge clk) begin
    if (bus.cwr && bus.crd) overlap_cnt <= overlap_cnt + 1;
    if (bus.cwr) begin
      if (bus.csel == 3'd1) begin
        bank1[bus.caddr_wr] <= bus.cdata_wr;
        conv_addr.push_back(bus.caddr_wr);
        conv_data.push_back(bus.cdata_wr);
      end else if (bus.csel == 3'd3) begin
        pool_addr.push_back(bus.caddr_wr);
        pool_data.push_back(bus.cdata_wr);
      end else begin
        bad_csel_cnt <= bad_csel_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " busy"},     32'(bus.busy),     32'd0);
    check_eq({tag, " cwr"},      32'(bus.cwr),      32'd0);
    check_eq({tag, " crd"},      32'(bus.crd),      32'd0);
    check_eq({tag, " iaddr"},    32'(bus.iaddr),    32'd0);
    check_eq({tag, " caddr_wr"}, 32'(bus.caddr_wr), 32'd0);
    check_eq({tag, " caddr_rd"}, 32'(bus.caddr_rd), 32'd0);
    check_eq({tag, " cdata_wr"}, 32'(bus.cdata_wr), 32'd0);
    check_eq({tag, " csel"},     32'(bus.csel),     32'd0);
  endtask

  task automatic set_kernel(input logic [DW-1:0] centre, input logic [DW-1:0] other,
                            input logic [DW-1:0] bias);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.k_we   = 1'b1;
      bus.k_idx  = 4'(i);
      bus.k_data = (i == 9) ? bias : (i == 4) ? centre : other;
    end
    @(negedge clk);
    bus.k_we = 1'b0;
  endtask

  // one start pulse; counts busy cycles; optional k_we pulse at busy cycle kwe_at
  task automatic run(input logic [1:0] mode, input int kwe_at, output int cyc);
    @(negedge clk);
    bus.pool_mode = mode;
    bus.ready     = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 5000) begin
      bus.k_we = (cyc == kwe_at);
      cyc++;
      @(negedge clk);
    end
    bus.k_we = 1'b0;
  endtask

  task automatic check_map(input string tag, input int base);
    for (int i = 0; i < NPIX; i++) begin
      if (base + i < conv_addr.size()) begin
        check_eq($sformatf("%s addr%0d", tag, i), 32'(conv_addr[base+i]), 32'(i));
        check_eq($sformatf("%s data%0d", tag, i), 32'(conv_data[base+i]), 32'(exp_map[i]));
      end
    end
  endtask

  task automatic check_pool(input string tag, input int base, input int e0, input int e1,
                            input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check_eq({tag, " n_wr"}, 32'(pool_addr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < pool_addr.size()) begin
        check_eq($sformatf("%s addr%0d", tag, i), 32'(pool_addr[base+i]), 32'(i));
        check_eq($sformatf("%s data%0d", tag, i), 32'(pool_data[base+i]), 32'(e[i]));
      end
    end
  endtask

  int cyc, cyc2, gap, cb, pb;

  initial begin
    reset         = 1'b0;
    bus.ready     = 1'b0;
    bus.k_we      = 1'b0;
    bus.k_idx     = 4'd0;
    bus.k_data    = '0;
    bus.pool_mode = 2'd0;
    for (int i = 0; i < NPIX; i++) rom[i] = 20'h55555;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    // zero kernel: every pixel is bias alone
    set_kernel(20'h0, 20'h0, 20'h01310);
    cb = conv_addr.size();
    run(2'd0, -1, cyc);
    check_eq("bias busy_cycles", 32'(cyc), 32'd177);
    check_eq("bias n_wr", 32'(conv_addr.size() - cb), 32'd16);
    for (int i = 0; i < NPIX; i++) exp_map[i] = 20'h01310;
    check_map("bias", cb);

    // all-0.5 kernel over all-1.0 image: 0.5 x neighbour count
    for (int i = 0; i < NPIX; i++) rom[i] = 20'h10000;
    set_kernel(20'h08000, 20'h08000, 20'h0);
    cb = conv_addr.size();
    run(2'd0, -1, cyc);
    for (int i = 0; i < NPIX; i++) exp_map[i] = 20'(nbr[i] * 32'h8000);
    check_map("half", cb);

    // all-1.0 kernel: 9.0 exceeds the signed 20-bit Q.16 range and wraps negative
    set_kernel(20'h10000, 20'h10000, 20'h0);
    cb = conv_addr.size();
    run(2'd0, -1, cyc);
    for (int i = 0; i < NPIX; i++) exp_map[i] = (nbr[i] == 9) ? 20'h0 : 20'(nbr[i] * 32'h10000);
    check_map("ones", cb);

    // identity kernel, pixel 5 = -1.0 clipped by ReLU
    for (int i = 0; i < NPIX; i++) rom[i] = 20'h08000;
    rom[5] = 20'hF0000;
    set_kernel(20'h10000, 20'h0, 20'h0);
    cb = conv_addr.size();
    run(2'd0, -1, cyc);
    for (int i = 0; i < NPIX; i++) exp_map[i] = 20'h08000;
    exp_map[5] = 20'h0;
    check_map("relu", cb);

    // 0.5 x 2^-16 rounds half up to one LSB
    for (int i = 0; i < NPIX; i++) rom[i] = 20'h00001;
    set_kernel(20'h08000, 20'h0, 20'h0);
    cb = conv_addr.size();
    run(2'd0, -1, cyc);
    for (int i = 0; i < NPIX; i++) exp_map[i] = 20'h00001;
    check_map("round", cb);

    // conv map 1..16, then max pool
    for (int i = 0; i < NPIX; i++) rom[i] = 20'(i + 1);
    for (int i = 0; i < NPIX; i++) exp_map[i] = 20'(i + 1);
    set_kernel(20'h10000, 20'h0, 20'h0);
    cb = conv_addr.size();
    pb = pool_addr.size();
    run(2'd1, -1, cyc);
    check_eq("max busy_cycles", 32'(cyc), 32'd201);
    check_map("max conv", cb);
    check_pool("max", pb, 6, 8, 14, 16);

    // avg pool, truncated
    pb = pool_addr.size();
    run(2'd2, -1, cyc);
    check_eq("avg busy_cycles", 32'(cyc), 32'd201);
    check_pool("avg", pb, 3, 5, 11, 13);

    // mode 3 behaves as conv only
    pb = pool_addr.size();
    run(2'd3, -1, cyc);
    check_eq("mode3 busy_cycles", 32'(cyc), 32'd177);
    check_eq("mode3 pool n_wr", 32'(pool_addr.size() - pb), 32'd0);

    // kernel write while busy is dropped
    bus.k_idx  = 4'd4;
    bus.k_data = 20'h20000;
    cb = conv_addr.size();
    run(2'd0, 20, cyc);
    check_map("kwe_busy", cb);
    cb = conv_addr.size();
    run(2'd0, -1, cyc);
    check_map("kwe_rerun", cb);

    // ready held high: back-to-back runs, one idle cycle between
    cb = conv_addr.size();
    @(negedge clk);
    bus.pool_mode = 2'd0;
    bus.ready     = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (bus.busy && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    gap = 0;
    while (!bus.busy && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    bus.ready = 1'b0;
    cyc2 = 0;
    while (bus.busy && cyc2 < 5000) begin
      cyc2++;
      @(negedge clk);
    end
    check_eq("b2b first busy_cycles", 32'(cyc), 32'd177);
    check_eq("b2b idle gap", 32'(gap), 32'd1);
    check_eq("b2b second busy_cycles", 32'(cyc2), 32'd177);
    check_eq("b2b n_wr", 32'(conv_addr.size() - cb), 32'd32);
    check_map("b2b first", cb);
    check_map("b2b second", cb + 16);

    // reset in the middle of pixel 7
    cb = conv_addr.size();
    @(negedge clk);
    bus.pool_mode = 2'd0;
    bus.ready     = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    repeat (80) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_idle_outputs("abort");
    check_eq("abort n_wr", 32'(conv_addr.size() - cb), 32'd7);
    repeat (2) @(negedge clk);
    check_eq("abort held n_wr", 32'(conv_addr.size() - cb), 32'd7);
    reset = 1'b1;

    // kernel and bias were cleared by reset
    cb = conv_addr.size();
    run(2'd0, -1, cyc);
    check_eq("cleared busy_cycles", 32'(cyc), 32'd177);
    for (int i = 0; i < NPIX; i++) exp_map[i] = 20'h0;
    check_map("cleared", cb);

    set_kernel(20'h10000, 20'h0, 20'h0);
    cb = conv_addr.size();
    run(2'd0, -1, cyc);
    check_eq("after_reset n_wr", 32'(conv_addr.size() - cb), 32'd16);
    for (int i = 0; i < NPIX; i++) exp_map[i] = 20'(i + 1);
    check_map("after_reset", cb);

    check_eq("crd_cwr overlap", 32'(overlap_cnt), 32'd0);
    check_eq("bad csel writes", 32'(bad_csel_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end
endmodule
